// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, fixed access latency,
// little-endian byte array, registered response with sign/zero-extended load data or error.
module dmem_responder #(
   parameter int unsigned ADDR_WIDTH = 17,
   parameter int unsigned LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam bit LAT1 = (LATENCY == 1);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        write_q;
   logic        unsigned_q;
   logic [1:0]  size_q;
   logic        req_ready_q;
   logic        resp_valid_q;
   logic        resp_err_q;
   logic [31:0] resp_rdata_q;

   logic [7:0]  mem_q [2**ADDR_WIDTH];

   logic [31:0]           act_addr;
   logic [31:0]           act_wdata;
   logic                  act_write;
   logic                  act_unsigned;
   logic [1:0]            act_size;
   logic                  act_err;
   logic                  misalign;
   logic                  bad_size;
   logic                  commit;
   logic                  mem_we;
   logic [3:0]            byte_en;
   logic [ADDR_WIDTH-1:0] base;
   logic [31:0]           rd_word;
   logic [31:0]           load_d;

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

   // With LATENCY==1 the access happens on the accept edge, so it must use the live request.
   always_comb begin
      if (LAT1) begin
         act_addr     = req_addr;
         act_wdata    = req_wdata;
         act_write    = req_write;
         act_unsigned = req_unsigned;
         act_size     = req_size;
      end else begin
         act_addr     = addr_q;
         act_wdata    = wdata_q;
         act_write    = write_q;
         act_unsigned = unsigned_q;
         act_size     = size_q;
      end

      byte_en  = 4'b0000;
      misalign = 1'b0;
      bad_size = 1'b0;
      unique case (act_size)
         2'b00: byte_en = 4'b0001;
         2'b01: begin
            byte_en  = 4'b0011;
            misalign = act_addr[0];
         end
         2'b10: begin
            byte_en  = 4'b1111;
            misalign = |act_addr[1:0];
         end
         default: bad_size = 1'b1;
      endcase

      act_err = bad_size | misalign | ((act_addr >> ADDR_WIDTH) != 32'd0);
      commit  = (state_q == IDLE && req_valid && LAT1) || (state_q == WAIT && cnt_q == 4'd1);
      mem_we  = rst & commit & act_write & ~act_err;

      base    = act_addr[ADDR_WIDTH-1:0];
      rd_word = {mem_q[base + ADDR_WIDTH'(3)], mem_q[base + ADDR_WIDTH'(2)],
                 mem_q[base + ADDR_WIDTH'(1)], mem_q[base]};

      load_d = '0;
      if (!act_write && !act_err) begin
         unique case (act_size)
            2'b00:   load_d = {{24{~act_unsigned & rd_word[7]}}, rd_word[7:0]};
            2'b01:   load_d = {{16{~act_unsigned & rd_word[15]}}, rd_word[15:0]};
            default: load_d = rd_word;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
               mem_q[base + ADDR_WIDTH'(i)] <= act_wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         write_q      <= 1'b0;
         unsigned_q   <= 1'b0;
         size_q       <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  addr_q      <= req_addr;
                  wdata_q     <= req_wdata;
                  write_q     <= req_write;
                  unsigned_q  <= req_unsigned;
                  size_q      <= req_size;
                  req_ready_q <= 1'b0;
                  cnt_q       <= 4'(LATENCY - 1);
                  if (LAT1) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_rdata_q <= load_d;
                     resp_err_q   <= act_err;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= load_d;
                  resp_err_q   <= act_err;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state_q      <= IDLE;
                  resp_valid_q <= 1'b0;
                  resp_rdata_q <= '0;
                  resp_err_q   <= 1'b0;
                  req_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

endmodule
